// File: rtl/chip8_key_unit.sv
// chip8_key_unit
//   Executes the CHIP-8 keypad instructions for the CPU core:
//     EX9E (SKP)  : skip next instruction if key Vx is pressed
//     EXA1 (SKNP) : skip next instruction if key Vx is not pressed
//     FX0A (WAIT) : block until a fresh, debounced key press, return its index
//   Commands arrive on a valid/ready handshake and results leave on a second
//   valid/ready handshake.
//
// Configuration macro:
//   WAIT_RELEASE_EN - when defined, FX0A completes only after the accepted
//                     key has also been released and held released for
//                     STABLE_CYCLES cycles (COSMAC VIP behaviour).
//
// Parameters:
//   STABLE_CYCLES   - consecutive cycles a key must hold a level before FX0A
//                     accepts a press (or release). Legal range 1..255.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   key_state  in   [15:0] one bit per key, 1 = pressed, synchronous to clk
//   cmd_valid  in   command offered
//   cmd_ready  out  unit can accept a command (high only in IDLE)
//   cmd_op     in   [1:0] 00 SKP, 01 SKNP, 10 WAIT, 11 reserved
//   cmd_key    in   [3:0] key index for SKP/SKNP, ignored by WAIT
//   cancel     in   synchronous abort of any in-flight command
//   rsp_valid  out  result available (high only in RESP)
//   rsp_ready  in   result consumed
//   rsp_skip   out  1 = skip next instruction (always 0 for WAIT)
//   rsp_key    out  [3:0] WAIT: accepted key; SKP/SKNP/reserved: cmd_key
//   busy       out  high whenever the unit is not IDLE

module chip8_key_unit #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] key_state,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_key,
  input  logic        cancel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_skip,
  output logic [3:0]  rsp_key,
  output logic        busy
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  localparam logic [1:0] OP_SKP  = 2'b00;
  localparam logic [1:0] OP_SKNP = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_RESP         = 2'd2
`ifdef WAIT_RELEASE_EN
    ,
    S_WAIT_RELEASE = 2'd3
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [3:0]  cand;
  logic        cand_valid;
  logic [15:0] prev_keys;

  logic [15:0] rise;
  logic        rise_any;
  logic [3:0]  rise_idx;
  logic        press_done;
`ifdef WAIT_RELEASE_EN
  logic        release_done;
`endif

  // Saturating increment of the stability counter.
  always_comb begin
    cnt_inc = (cnt == STAB) ? cnt : cnt + 8'd1;
  end

  // Keys that went from released to pressed since the previous sample.
  // Keys already held when WAIT was accepted are masked by prev_keys.
  always_comb begin
    rise     = key_state & ~prev_keys;
    rise_any = |rise;
  end

  // Lowest-index new press wins a tie.
  always_comb begin
    logic found;
    found    = 1'b0;
    rise_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (rise[i] && !found) begin
        rise_idx = 4'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    press_done = cand_valid && (cnt == STAB);
  end

`ifdef WAIT_RELEASE_EN
  always_comb begin
    release_done = (cnt == STAB);
  end
`endif

  // Next-state decode; cancel overrides every other transition out of a
  // busy state, including the response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_op == OP_WAIT) ? S_WAIT_PRESS : S_RESP;
        end
      end
      S_WAIT_PRESS: begin
        if (cancel) begin
          state_nxt = S_IDLE;
        end else if (press_done) begin
`ifdef WAIT_RELEASE_EN
          state_nxt = S_WAIT_RELEASE;
`else
          state_nxt = S_RESP;
`endif
        end
      end
`ifdef WAIT_RELEASE_EN
      S_WAIT_RELEASE: begin
        if (cancel) begin
          state_nxt = S_IDLE;
        end else if (release_done) begin
          state_nxt = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (cancel || rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, registered handshake outputs (decoded from the next state so they
  // are valid in the same cycle as the state they describe) and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      rsp_skip   <= 1'b0;
      rsp_key    <= '0;
      cnt        <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
      prev_keys  <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
      busy      <= (state_nxt != S_IDLE);

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_SKP: begin
                rsp_skip <= key_state[cmd_key];
                rsp_key  <= cmd_key;
              end
              OP_SKNP: begin
                rsp_skip <= ~key_state[cmd_key];
                rsp_key  <= cmd_key;
              end
              OP_WAIT: begin
                rsp_skip   <= 1'b0;
                prev_keys  <= key_state;
                cnt        <= '0;
                cand_valid <= 1'b0;
              end
              default: begin
                rsp_skip <= 1'b0;
                rsp_key  <= cmd_key;
              end
            endcase
          end
        end

        S_WAIT_PRESS: begin
          prev_keys <= key_state;
          if (press_done) begin
            rsp_key    <= cand;
            rsp_skip   <= 1'b0;
            cand_valid <= 1'b0;
            // Cleared so a release-stability count starts from zero.
            cnt        <= '0;
          end else if (!cand_valid) begin
            if (rise_any) begin
              cand       <= rise_idx;
              cand_valid <= 1'b1;
              cnt        <= 8'd1;
            end
          end else if (key_state[cand]) begin
            cnt <= cnt_inc;
          end else begin
            // Candidate bounced low; prev_keys now holds 0 for it, so its
            // next rising sample re-arms it as a fresh press.
            cand_valid <= 1'b0;
            cnt        <= '0;
          end
        end

`ifdef WAIT_RELEASE_EN
        S_WAIT_RELEASE: begin
          if (!key_state[rsp_key]) begin
            cnt <= cnt_inc;
          end else begin
            cnt <= '0;
          end
        end
`endif

        default: begin
        end
      endcase
    end
  end

endmodule
